// File: rtl/btn_pkg.sv
// Shared constants and helpers for the button input bank: default clocking,
// debounce/repeat tick counts, prescaler divide helper and board button map.
package btn_pkg;

   localparam int DEFAULT_CLKIN_FREQ     = 27_000_000;
   localparam int DEFAULT_TICK_HZ        = 10_000;
   localparam int DEFAULT_DEBOUNCE_TICKS = 10;
   localparam int DEFAULT_HOLD_TICKS     = 5000;
   localparam int DEFAULT_REPEAT_TICKS   = 1000;

   // Board button map, channel index into the bank vectors
   localparam int BTN_CH_UP    = 0;
   localparam int BTN_CH_DOWN  = 1;
   localparam int BTN_CH_LEFT  = 2;
   localparam int BTN_CH_RIGHT = 3;

   // Clock cycles per sample tick, never below one so the prescaler always wraps
   function automatic int tickDiv(input int clkinFreq, input int tickHz);
      int div;
      div = (tickHz > 0) ? (clkinFreq / tickHz) : 1;
      return (div < 1) ? 1 : div;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One debounced input channel: synchronizer, stable-tick counter, level and
// press/release pulse registers; auto-repeat hold counter under BTN_AUTOREPEAT_EN.
module btn_channel
   import btn_pkg::*;
#(
   parameter logic IDLE_LEVEL     = 1'b1,
   parameter int   DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
`ifdef BTN_AUTOREPEAT_EN
   ,
   parameter int   HOLD_TICKS     = DEFAULT_HOLD_TICKS,
   parameter int   REPEAT_TICKS   = DEFAULT_REPEAT_TICKS
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic noisyIn,
   output logic debounceOut,
   output logic pressPulse,
   output logic releasePulse
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

   logic          syncA;
   logic          syncB;
   logic          syncPressed;
   logic [CW-1:0] stableCnt;
   logic          accept;
   logic          repeatFire;

   // Two-flop synchronizer, parked at the idle level so reset never looks like a press
   always_ff @(posedge clk) begin
      if (reset) begin
         syncA <= IDLE_LEVEL;
         syncB <= IDLE_LEVEL;
      end else begin
         syncA <= noisyIn;
         syncB <= syncA;
      end
   end

   assign syncPressed = syncB ^ IDLE_LEVEL;
   assign accept      = tick && (syncPressed != debounceOut)
                        && (stableCnt == CW'(DEBOUNCE_TICKS - 1));

   // Any sample back at the current level restarts the count; acceptance flips the level
   always_ff @(posedge clk) begin
      if (reset) begin
         stableCnt    <= '0;
         debounceOut  <= 1'b0;
         pressPulse   <= 1'b0;
         releasePulse <= 1'b0;
      end else begin
         pressPulse   <= (accept && !debounceOut) || repeatFire;
         releasePulse <= accept && debounceOut;
         if (syncPressed == debounceOut) begin
            stableCnt <= '0;
         end else if (accept) begin
            stableCnt   <= '0;
            debounceOut <= ~debounceOut;
         end else if (tick) begin
            stableCnt <= stableCnt + CW'(1);
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int HW   = $clog2(HMAX + 1);

   logic [HW-1:0] holdCnt;
   logic          repeating;

   // First repeat waits HOLD_TICKS, later ones REPEAT_TICKS; a release acceptance wins
   assign repeatFire = tick && debounceOut && !accept &&
                       (repeating ? (holdCnt == HW'(REPEAT_TICKS - 1))
                                  : (holdCnt == HW'(HOLD_TICKS - 1)));

   always_ff @(posedge clk) begin
      if (reset || !debounceOut || accept) begin
         holdCnt   <= '0;
         repeating <= 1'b0;
      end else if (tick) begin
         if (repeatFire) begin
            holdCnt   <= '0;
            repeating <= 1'b1;
         end else begin
            holdCnt <= holdCnt + HW'(1);
         end
      end
   end
`else
   assign repeatFire = 1'b0;
`endif

endmodule

// File: rtl/btn_input_bank.sv
// Bank of debounced button inputs sharing one sample-tick prescaler.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module btn_input_bank
   import btn_pkg::*;
#(
   parameter int                    CLKIN_FREQ     = DEFAULT_CLKIN_FREQ,
   parameter int                    TICK_HZ        = DEFAULT_TICK_HZ,
   parameter int                    NUM_CHANNELS   = 4,
   parameter logic [NUM_CHANNELS-1:0] IDLE_MASK    = '1,
   parameter int                    DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
   parameter int                    HOLD_TICKS     = DEFAULT_HOLD_TICKS,
   parameter int                    REPEAT_TICKS   = DEFAULT_REPEAT_TICKS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CHANNELS-1:0] noisyIn,
   output logic [NUM_CHANNELS-1:0] debounceOut,
   output logic [NUM_CHANNELS-1:0] pressPulse,
   output logic [NUM_CHANNELS-1:0] releasePulse,
   output logic                    anyPressed
);

   localparam int TICK_DIV = tickDiv(CLKIN_FREQ, TICK_HZ);
   localparam int PW       = $clog2(TICK_DIV + 1);

   logic [PW-1:0] prescale;
   logic          tick;

   assign tick = (prescale == PW'(TICK_DIV - 1));

   // Free-running prescaler shared by every channel
   always_ff @(posedge clk) begin
      if (reset || tick) begin
         prescale <= '0;
      end else begin
         prescale <= prescale + PW'(1);
      end
   end

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : gChannel
      btn_channel #(
         .IDLE_LEVEL    (IDLE_MASK[i]),
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
`ifdef BTN_AUTOREPEAT_EN
         ,
         .HOLD_TICKS    (HOLD_TICKS),
         .REPEAT_TICKS  (REPEAT_TICKS)
`endif
      ) uChannel (
         .clk         (clk),
         .reset       (reset),
         .tick        (tick),
         .noisyIn     (noisyIn[i]),
         .debounceOut (debounceOut[i]),
         .pressPulse  (pressPulse[i]),
         .releasePulse(releasePulse[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         anyPressed <= 1'b0;
      end else begin
         anyPressed <= |debounceOut;
      end
   end

endmodule

// File: tb/tb_btn_input_bank.sv
// Self-checking bench for btn_input_bank against a timestamp-based reference model;
// the auto-repeat scenario follows BTN_AUTOREPEAT_EN.
module tb_btn_input_bank;

   localparam int CLKIN_FREQ = 1000;
   localparam int TICK_HZ    = 100;
   localparam int TICK_DIV   = 10;
   localparam int NUM_CH     = 2;
   localparam int DEB        = 3;
   localparam int HOLD       = 5;
   localparam int REP        = 2;
   localparam logic [1:0] IDLE = 2'b11;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NUM_CH-1:0] noisyIn = IDLE;
   logic [NUM_CH-1:0] debounceOut;
   logic [NUM_CH-1:0] pressPulse;
   logic [NUM_CH-1:0] releasePulse;
   logic              anyPressed;

   always #5 clk = ~clk;

   btn_input_bank #(
      .CLKIN_FREQ    (CLKIN_FREQ),
      .TICK_HZ       (TICK_HZ),
      .NUM_CHANNELS  (NUM_CH),
      .IDLE_MASK     (IDLE),
      .DEBOUNCE_TICKS(DEB),
      .HOLD_TICKS    (HOLD),
      .REPEAT_TICKS  (REP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .noisyIn     (noisyIn),
      .debounceOut (debounceOut),
      .pressPulse  (pressPulse),
      .releasePulse(releasePulse),
      .anyPressed  (anyPressed)
   );

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;
   int cycle = 0;

   // Reference model: a change is accepted once DEB ticks have elapsed since the
   // synchronized input last agreed with the accepted level
   logic [1:0] mS1 = IDLE, mS2 = IDLE;
   logic [1:0] mLevel = '0, mPress = '0, mRelease = '0;
   logic       mAny = 1'b0;
   bit         mWasReset = 1'b1;
   int         phase = 0;
   int         tickTotal = 0;
   int         lastEq [NUM_CH];
   int         acceptTick [NUM_CH];
   bit         tickNow;
   logic [1:0] sp, oldLevel;
`ifdef BTN_AUTOREPEAT_EN
   int         elapsed;
`endif

   always @(posedge clk) begin
      if (reset) begin
         mS1 = IDLE; mS2 = IDLE; phase = 0;
         mLevel = '0; mPress = '0; mRelease = '0; mAny = 1'b0;
         mWasReset = 1'b1;
         for (int c = 0; c < NUM_CH; c++) begin
            lastEq[c] = tickTotal;
            acceptTick[c] = tickTotal;
         end
      end else begin
         mWasReset = 1'b0;
         tickNow = (phase == TICK_DIV - 1);
         if (tickNow) tickTotal++;
         sp = mS2 ^ IDLE;
         oldLevel = mLevel;
         mAny = |oldLevel;
         for (int c = 0; c < NUM_CH; c++) begin
            mPress[c] = 1'b0;
            mRelease[c] = 1'b0;
            if (sp[c] == oldLevel[c]) begin
               lastEq[c] = tickTotal;
            end else if (tickNow && (tickTotal - lastEq[c] >= DEB)) begin
               mLevel[c] = ~oldLevel[c];
               lastEq[c] = tickTotal;
               if (mLevel[c]) begin
                  mPress[c] = 1'b1;
                  acceptTick[c] = tickTotal;
               end else begin
                  mRelease[c] = 1'b1;
               end
            end
`ifdef BTN_AUTOREPEAT_EN
            if (tickNow && oldLevel[c] && mLevel[c]) begin
               elapsed = tickTotal - acceptTick[c];
               if (elapsed == HOLD || (elapsed > HOLD && ((elapsed - HOLD) % REP) == 0))
                  mPress[c] = 1'b1;
            end
`endif
         end
         mS2 = mS1;
         mS1 = noisyIn;
         phase = (phase + 1) % TICK_DIV;
      end
   end

   // Per-cycle comparison against the model, plus pulse bookkeeping for scenarios
   int         pressCount [NUM_CH];
   int         releaseCount [NUM_CH];
   bit         sawBothPress = 1'b0;
   bit         sawBothRelease = 1'b0;
   logic [1:0] prevDeb = '0;

   always @(negedge clk) begin
      cycle++;
      if (checking) begin
         checks++;
         if (debounceOut !== mLevel) begin
            errors++;
            if (errors <= 30) $display("[TB] FAIL debounceOut cycle %0d: got %b expected %b", cycle, debounceOut, mLevel);
         end
         checks++;
         if (pressPulse !== mPress) begin
            errors++;
            if (errors <= 30) $display("[TB] FAIL pressPulse cycle %0d: got %b expected %b", cycle, pressPulse, mPress);
         end
         checks++;
         if (releasePulse !== mRelease) begin
            errors++;
            if (errors <= 30) $display("[TB] FAIL releasePulse cycle %0d: got %b expected %b", cycle, releasePulse, mRelease);
         end
         checks++;
         if (anyPressed !== mAny) begin
            errors++;
            if (errors <= 30) $display("[TB] FAIL anyPressed cycle %0d: got %b expected %b", cycle, anyPressed, mAny);
         end
         if (!mWasReset) begin
            checks++;
            if (anyPressed !== |prevDeb) begin
               errors++;
               if (errors <= 30) $display("[TB] FAIL anyPressedLag cycle %0d: got %b expected %b", cycle, anyPressed, |prevDeb);
            end
         end
         checks++;
         if ((pressPulse & releasePulse) !== 2'b00) begin
            errors++;
            if (errors <= 30) $display("[TB] FAIL pulseExclusive cycle %0d: got press %b release %b expected no overlap", cycle, pressPulse, releasePulse);
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (pressPulse[c] === 1'b1) pressCount[c]++;
            if (releasePulse[c] === 1'b1) releaseCount[c]++;
         end
         if (pressPulse === 2'b11) sawBothPress = 1'b1;
         if (releasePulse === 2'b11) sawBothRelease = 1'b1;
      end
      prevDeb = debounceOut;
   end

   task automatic applyStimulus(input logic [1:0] val, input int cycles);
      @(negedge clk);
      noisyIn = val;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic test_reset();
      int pulsesBefore, pulsesAfter, badLevel;
      $display("[TB] test_reset");
      reset = 1'b1;
      noisyIn = IDLE;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checking = 1'b1;
      pulsesBefore = pressCount[0] + pressCount[1] + releaseCount[0] + releaseCount[1];
      badLevel = 0;
      repeat (200) begin
         @(negedge clk);
         if (debounceOut !== 2'b00 || anyPressed !== 1'b0) badLevel++;
      end
      pulsesAfter = pressCount[0] + pressCount[1] + releaseCount[0] + releaseCount[1];
      checks++;
      if (pulsesAfter - pulsesBefore != 0) begin
         errors++;
         $display("[TB] FAIL resetIdlePulses: got %0d pulses expected 0", pulsesAfter - pulsesBefore);
      end
      checks++;
      if (badLevel != 0) begin
         errors++;
         $display("[TB] FAIL resetIdleLevel: got %0d cycles with outputs set expected 0", badLevel);
      end
   endtask

   task automatic test_press();
      int p0, p1, r0, lat;
      $display("[TB] test_press");
      p0 = pressCount[0]; p1 = pressCount[1]; r0 = releaseCount[0];
      @(negedge clk);
      noisyIn = 2'b10;
      lat = 0;
      while (debounceOut[0] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (debounceOut[0] !== 1'b1 || lat > 2 + DEB * TICK_DIV) begin
         errors++;
         $display("[TB] FAIL pressLatency: got %0d cycles expected at most %0d", lat, 2 + DEB * TICK_DIV);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (pressCount[0] - p0 != 1) begin
         errors++;
         $display("[TB] FAIL pressOnce: got %0d pulses expected 1", pressCount[0] - p0);
      end
      checks++;
      if (pressCount[1] - p1 != 0 || debounceOut[1] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ch1Isolation: got %0d pulses level %b expected 0 and 0", pressCount[1] - p1, debounceOut[1]);
      end
      noisyIn = IDLE;
      lat = 0;
      while (debounceOut[0] !== 1'b0 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (releaseCount[0] - r0 != 1) begin
         errors++;
         $display("[TB] FAIL releaseOnce: got %0d pulses expected 1", releaseCount[0] - r0);
      end
   endtask

   task automatic test_bounce();
      int p0, r0;
      logic hi;
      $display("[TB] test_bounce");
      p0 = pressCount[0]; r0 = releaseCount[0];
      hi = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i % 7 == 0) noisyIn[0] = ~noisyIn[0];
         hi = hi | debounceOut[0];
      end
      noisyIn = IDLE;
      repeat (40) begin
         @(negedge clk);
         hi = hi | debounceOut[0];
      end
      checks++;
      if (hi !== 1'b0 || pressCount[0] != p0 || releaseCount[0] != r0) begin
         errors++;
         $display("[TB] FAIL bounceRejected: got level %b presses %0d releases %0d expected 0 0 0", hi, pressCount[0] - p0, releaseCount[0] - r0);
      end
   endtask

   task automatic test_simultaneous();
      int lat;
      $display("[TB] test_simultaneous");
      sawBothPress = 1'b0;
      applyStimulus(2'b00, 0);
      lat = 0;
      while (debounceOut !== 2'b11 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (!sawBothPress || debounceOut !== 2'b11 || anyPressed !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bothPress: got both=%0d level %b any %b expected 1 11 1", sawBothPress, debounceOut, anyPressed);
      end
      sawBothRelease = 1'b0;
      noisyIn = IDLE;
      lat = 0;
      while (debounceOut !== 2'b00 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (!sawBothRelease || debounceOut !== 2'b00 || anyPressed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bothRelease: got both=%0d level %b any %b expected 1 00 0", sawBothRelease, debounceOut, anyPressed);
      end
   endtask

   task automatic test_reset_mid_count();
      int guard, lat, p0, r0;
      $display("[TB] test_reset_mid_count");
      @(negedge clk);
      noisyIn = 2'b10;
      guard = 0;
      while (!((tickTotal - lastEq[0]) == 2 && mLevel[0] == 1'b0) && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 40) begin
         errors++;
         $display("[TB] FAIL midCountReached: got timeout after %0d cycles expected 2 ticks counted", guard);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (debounceOut !== 2'b00 || pressPulse !== 2'b00) begin
         errors++;
         $display("[TB] FAIL midCountReset: got level %b press %b expected 00 00", debounceOut, pressPulse);
      end
      p0 = pressCount[0];
      lat = 0;
      while (debounceOut[0] !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat <= 2 * TICK_DIV || lat > 2 + DEB * TICK_DIV) begin
         errors++;
         $display("[TB] FAIL freshCount: got %0d cycles expected %0d..%0d", lat, 2 * TICK_DIV + 1, 2 + DEB * TICK_DIV);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (pressCount[0] - p0 != 1) begin
         errors++;
         $display("[TB] FAIL pressAfterReset: got %0d pulses expected 1", pressCount[0] - p0);
      end
      r0 = releaseCount[0];
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      noisyIn = IDLE;
      checks++;
      if (debounceOut !== 2'b00 || anyPressed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL resetWhilePressed: got level %b any %b expected 00 0", debounceOut, anyPressed);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (releaseCount[0] - r0 != 0) begin
         errors++;
         $display("[TB] FAIL noReleaseOnReset: got %0d pulses expected 0", releaseCount[0] - r0);
      end
   endtask

   task automatic test_autorepeat();
      int times[$];
      int lat, p0;
      $display("[TB] test_autorepeat");
      @(negedge clk);
      noisyIn = 2'b10;
      for (int i = 1; i <= 150; i++) begin
         @(negedge clk);
         if (pressPulse[0] === 1'b1) times.push_back(i);
      end
`ifdef BTN_AUTOREPEAT_EN
      checks++;
      if (times.size() != 5) begin
         errors++;
         $display("[TB] FAIL repeatCount: got %0d pulses expected 5", times.size());
      end
      if (times.size() >= 2) begin
         checks++;
         if (times[1] - times[0] != HOLD * TICK_DIV) begin
            errors++;
            $display("[TB] FAIL firstRepeat: got %0d cycles expected %0d", times[1] - times[0], HOLD * TICK_DIV);
         end
      end
      for (int k = 2; k < times.size(); k++) begin
         checks++;
         if (times[k] - times[k-1] != REP * TICK_DIV) begin
            errors++;
            $display("[TB] FAIL repeatGap%0d: got %0d cycles expected %0d", k, times[k] - times[k-1], REP * TICK_DIV);
         end
      end
`else
      checks++;
      if (times.size() != 1) begin
         errors++;
         $display("[TB] FAIL singlePressHeld: got %0d pulses expected 1", times.size());
      end
`endif
      noisyIn = IDLE;
      lat = 0;
      while (debounceOut[0] !== 1'b0 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      repeat (2) @(negedge clk);
      p0 = pressCount[0];
      repeat (60) @(negedge clk);
      checks++;
      if (pressCount[0] - p0 != 0 || debounceOut[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL repeatStops: got %0d pulses level %b expected 0 0", pressCount[0] - p0, debounceOut[0]);
      end
   endtask

   task automatic test_random();
      int total;
      $display("[TB] test_random");
      total = 0;
      while (total < 1500) begin
         int len;
         len = $urandom_range(1, 35);
         if ($urandom_range(0, 39) == 0) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            total += 2;
         end
         applyStimulus(2'($urandom_range(0, 3)), len);
         total += len + 1;
      end
      applyStimulus(IDLE, 40);
      checks++;
      if (debounceOut !== 2'b00 || anyPressed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL randomSettle: got level %b any %b expected 00 0", debounceOut, anyPressed);
      end
   endtask

   initial begin
      for (int c = 0; c < NUM_CH; c++) begin
         lastEq[c] = 0; acceptTick[c] = 0;
         pressCount[c] = 0; releaseCount[c] = 0;
      end
      test_reset();
      test_press();
      test_bounce();
      test_simultaneous();
      test_reset_mid_count();
      test_autorepeat();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/btn_input_bank.md
# btn_input_bank

Multi-channel successor to the single-button debouncer. Debounces `NUM_CHANNELS` asynchronous button or switch inputs against one shared tick prescaler. Each channel reports an active-high debounced level plus single-cycle press and release pulses. Sits between board pins and the game/input logic, replacing per-button debouncer instances.

## Interface
- `CLKIN_FREQ`, 27_000_000: input clock frequency in Hz.
- `TICK_HZ`, 10_000: sample tick rate. `TICK_DIV = CLKIN_FREQ / TICK_HZ` cycles per tick, integer, ≥1.
- `NUM_CHANNELS`, 4: number of independent inputs, ≥1.
- `IDLE_MASK`, all ones: per-channel idle level of `noisyIn`. Bit=1 means active-low button with pull-up.
- `DEBOUNCE_TICKS`, 10: consecutive stable ticks required to accept a change (1 ms at defaults), ≥1.
- `HOLD_TICKS`, 5000: ticks held before the first auto-repeat (macro only).
- `REPEAT_TICKS`, 1000: ticks between later auto-repeats (macro only).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `noisyIn` in `NUM_CHANNELS`: raw asynchronous inputs.
- `debounceOut` out `NUM_CHANNELS`: debounced level; 1 = pressed (non-idle), regardless of polarity.
- `pressPulse` out `NUM_CHANNELS`: one-cycle pulse on accepted press (and on auto-repeat).
- `releasePulse` out `NUM_CHANNELS`: one-cycle pulse on accepted release.
- `anyPressed` out 1: OR of `debounceOut`, registered.

## Operation
- Per channel: 2-FF synchronizer, then XOR with `IDLE_MASK` bit, giving `syncPressed`.
- Prescaler: counts 0..`TICK_DIV`-1 and asserts `tick` for one cycle at `TICK_DIV`-1, then wraps to 0. Free-running and shared by all channels.
- Stable counter per channel, width `$clog2(DEBOUNCE_TICKS+1)`:
  - If `syncPressed == debounceOut`: counter ← 0.
  - Else on `tick`: counter increments. If the counter equals `DEBOUNCE_TICKS`-1 at that tick, `debounceOut` toggles, counter ← 0, and `pressPulse` (rising) or `releasePulse` (falling) asserts the same cycle.
- A bounce back to the current level before acceptance restarts the count from 0. This is symmetric: press and release are debounced alike.
- Channels are fully independent. Simultaneous acceptances on several channels in one cycle are all reported.
- `pressPulse` and `releasePulse` of one channel never assert in the same cycle.
- Reset (also mid-count): synchronizers ← idle level, all counters ← 0, `debounceOut` ← 0, pulses ← 0, `anyPressed` ← 0. No pulses are emitted because of reset.

## Timing
- Latency from an input edge to `debounceOut`/pulse: 2 cycles (sync) + wait to the next tick + (`DEBOUNCE_TICKS`-1) further ticks. Bounded by 2 + `DEBOUNCE_TICKS`·`TICK_DIV` cycles.
- A change must stay stable across `DEBOUNCE_TICKS` consecutive tick samples to be accepted.
- All outputs are registered. Pulses are exactly 1 cycle wide.
- `anyPressed` lags `debounceOut` by 1 cycle.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - Per-channel hold counter counts ticks while `debounceOut`=1.
  - `pressPulse` reasserts at hold count `HOLD_TICKS`, then every `REPEAT_TICKS` ticks.
  - The hold counter clears on release and on reset.
- `BTN_AUTOREPEAT_EN` undefined: no hold counters. `pressPulse` fires once per accepted press. `HOLD_TICKS` and `REPEAT_TICKS` are ignored.
- Ports are identical in both builds.

## Structure
- Shared package `btn_pkg`:
  - Default `CLKIN_FREQ`, `TICK_HZ` and tick-count constants.
  - Helper function for computing `TICK_DIV`.
  - Channel-index constants for the board button map.
- Sub-module `btn_channel`: synchronizer, stable counter, level/pulse registers, and the optional hold/repeat counter. It takes `tick` as an input.
- Top level holds the prescaler, a generate loop over `btn_channel`, and the `anyPressed` OR.

## Test plan
Bench parameters: `CLKIN_FREQ`=1000, `TICK_HZ`=100 (`TICK_DIV`=10), `DEBOUNCE_TICKS`=3, `NUM_CHANNELS`=2, `IDLE_MASK`=2'b11.
- Reset release, inputs idle (2'b11) for 200 cycles → all outputs 0, no pulses.
- Ch0 driven 0 and held → `debounceOut[0]`=1 within 2+30 cycles, exactly one `pressPulse[0]`. Ch1 unaffected.
- Ch0 toggling every 7 cycles for 100 cycles, then held 1 → `debounceOut[0]` stays 0, no pulses.
- Both channels pressed in the same cycle, then released → simultaneous `pressPulse`=2'b11, later `releasePulse`=2'b11, `anyPressed` tracks with 1-cycle lag.
- `reset` asserted mid-count (after 2 ticks) and while pressed → outputs 0 next cycle, no `releasePulse`. A fresh 3-tick count is required after reset.
- With `BTN_AUTOREPEAT_EN`, `HOLD_TICKS`=5, `REPEAT_TICKS`=2, ch0 held 150 cycles → initial `pressPulse`, repeat at +50 cycles, then every 20 cycles. Repeats stop on release.
